// File: rtl/gpio_mux_pkg.sv
// Shared constants for the per-pin GPIO multiplexer: register map, select field layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_mux_pkg;

    // Register offsets inside the 256-byte window
    localparam logic [7:0] SEL_BASE   = 8'h00;
    localparam logic [7:0] CTRL_OFF   = 8'h40;
    localparam logic [7:0] STATUS_OFF = 8'h44;

    // Select field layout: eight 4-bit fields per 32-bit SEL word
    localparam int SEL_FIELD_W   = 4;
    localparam int PINS_PER_WORD = 8;

    // Commit sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    // STATUS register bits
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DROP_BIT = 1;

    // Effective owner of a pin: out-of-range selects behave as parked
    function automatic logic [SEL_FIELD_W-1:0] sel_eff(input logic [SEL_FIELD_W-1:0] sel,
                                                       input logic [SEL_FIELD_W-1:0] num_teams);
        return (sel > num_teams) ? '0 : sel;
    endfunction

endpackage

// File: rtl/gpio_mux_pin_sel.sv
// Combinational selector for one pin: picks the owning team's out/oeb, parks when unowned.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module gpio_mux_pin_sel
    import gpio_mux_pkg::*;
#(
    parameter int NUM_TEAMS = 12
) (
    input  logic [SEL_FIELD_W-1:0] sel_i,
    input  logic [NUM_TEAMS-1:0]   team_out_i,
    input  logic [NUM_TEAMS-1:0]   team_oeb_i,
    output logic                   pin_out_o,
    output logic                   pin_oeb_o
);

    // Select 0 and any value above NUM_TEAMS match no team, leaving the pin parked
    always_comb begin
        pin_out_o = 1'b0;
        pin_oeb_o = 1'b1;
        for (int t = 1; t <= NUM_TEAMS; t++) begin
            if (sel_i == SEL_FIELD_W'(t)) begin
                pin_out_o = team_out_i[t-1];
                pin_oeb_o = team_oeb_i[t-1];
            end
        end
    end

endmodule

// File: rtl/gpio_mux_wb.sv
// Wishbone-controlled per-pin GPIO mux with staged selects and a blanking commit sequence.
// Latency: bus ack 1 cycle after request; designs_* to gpio_* 1 cycle (registered).
// Backpressure: at most one ack per two cycles; writes during a commit are acked and dropped.
module gpio_mux_wb
    import gpio_mux_pkg::*;
#(
    parameter int          NUM_TEAMS    = 12,
    parameter int          NUM_PINS     = 34,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          BLANK_CYCLES = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_dat_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_out,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_oeb,
    output logic [NUM_PINS-1:0]           gpio_out,
    output logic [NUM_PINS-1:0]           gpio_oeb,
    output logic                          busy_o
);

    localparam logic [SEL_FIELD_W-1:0] TEAMS_W = SEL_FIELD_W'(NUM_TEAMS);
    localparam logic [7:0]             CNT_INIT = 8'(BLANK_CYCLES - 1);

    logic [SEL_FIELD_W-1:0] shadow_q [NUM_PINS];
    logic [SEL_FIELD_W-1:0] shadow_d [NUM_PINS];
    logic [SEL_FIELD_W-1:0] active_q [NUM_PINS];
    logic [SEL_FIELD_W-1:0] active_d [NUM_PINS];
    logic [NUM_PINS-1:0]    mask_q, mask_d;
    logic [1:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [NUM_PINS-1:0]    gpio_out_q, gpio_out_d;
    logic [NUM_PINS-1:0]    gpio_oeb_q, gpio_oeb_d;
    logic [NUM_PINS-1:0]    pin_out, pin_oeb;
    logic [31:0]            rd_data;

    // Bus decode; misaligned offsets fall into the "ack, read 0" space
    logic       in_win, req, wr, busy;
    logic       hit_sel, hit_ctrl, hit_status;
    logic       sel_wr, commit_req, drop_clr, drop_set;
    logic [7:0] off;
    logic [3:0] sel_word;

    assign in_win     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off        = wbs_adr_i[7:0];
    assign sel_word   = off[5:2];
    assign req        = wbs_cyc_i & wbs_stb_i & in_win & ~ack_q;
    assign wr         = req & wbs_we_i;
    assign busy       = (state_q != ST_IDLE);
    assign hit_sel    = (off[7:6] == SEL_BASE[7:6]) && (off[1:0] == 2'b00);
    assign hit_ctrl   = (off == CTRL_OFF);
    assign hit_status = (off == STATUS_OFF);
    assign sel_wr     = wr & hit_sel;
    assign commit_req = wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
    assign drop_clr   = wr & hit_status & wbs_sel_i[0] & wbs_dat_i[STAT_DROP_BIT];
    assign drop_set   = busy & (sel_wr | commit_req);

    // Read mux: SEL words gather their fields, STATUS reports busy/drop, all else reads 0
    always_comb begin
        rd_data = '0;
        if (hit_sel) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (sel_word == 4'(p / PINS_PER_WORD)) begin
                    rd_data[SEL_FIELD_W*(p % PINS_PER_WORD) +: SEL_FIELD_W] = shadow_q[p];
                end
            end
        end else if (hit_status) begin
            rd_data[STAT_BUSY_BIT] = busy;
            rd_data[STAT_DROP_BIT] = drop_q;
        end
    end

    // Shadow writes, drop flag and commit sequencer next-state
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        mask_d   = mask_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        ack_d    = req;
        dat_d    = req ? rd_data : 32'h0;

        if (sel_wr && !busy) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (sel_word == 4'(p / PINS_PER_WORD) && wbs_sel_i[(p % PINS_PER_WORD) / 2]) begin
                    shadow_d[p] = wbs_dat_i[SEL_FIELD_W*(p % PINS_PER_WORD) +: SEL_FIELD_W];
                end
            end
        end

        // A new drop wins over a same-cycle clear
        if (drop_clr) drop_d = 1'b0;
        if (drop_set) drop_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_INIT;
                    for (int p = 0; p < NUM_PINS; p++) begin
                        mask_d[p] = (sel_eff(shadow_q[p], TEAMS_W) != sel_eff(active_q[p], TEAMS_W));
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == 8'd0) state_d = ST_APPLY;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_APPLY: begin
                active_d = shadow_q;
                mask_d   = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-pin selectors driven from the next-state select so blanking aligns with busy
    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [NUM_TEAMS-1:0] team_out, team_oeb;
        for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
            assign team_out[t] = designs_gpio_out[t*NUM_PINS + p];
            assign team_oeb[t] = designs_gpio_oeb[t*NUM_PINS + p];
        end
        gpio_mux_pin_sel #(.NUM_TEAMS(NUM_TEAMS)) u_pin_sel (
            .sel_i      (active_d[p]),
            .team_out_i (team_out),
            .team_oeb_i (team_oeb),
            .pin_out_o  (pin_out[p]),
            .pin_oeb_o  (pin_oeb[p])
        );
    end

    // Pins being re-routed are forced to high-Z with output low
    always_comb begin
        gpio_out_d = pin_out & ~mask_d;
        gpio_oeb_d = pin_oeb | mask_d;
    end

    // State, bus response and pin output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                shadow_q[p] <= '0;
                active_q[p] <= '0;
            end
            mask_q     <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            gpio_out_q <= '0;
            gpio_oeb_q <= '1;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            gpio_out_q <= gpio_out_d;
            gpio_oeb_q <= gpio_oeb_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = gpio_out_q;
    assign gpio_oeb  = gpio_oeb_q;
    assign busy_o    = busy;

endmodule

// File: doc/gpio_mux_wb.md
Name: gpio_mux_wb

Overview:
- Wishbone-controlled per-pin GPIO multiplexer. Generalised successor to the single-team GPIO control wrapper.
- Each of NUM_PINS pins is independently routed to one of NUM_TEAMS designs, or parked (tri-stated).
- Routing changes are staged in shadow registers. A glitch-safe commit sequence applies them: pins whose routing changes are driven to high-Z for BLANK_CYCLES before the new owner takes over.
- Sits between the Caravel Wishbone bus / team designs and the top-level io_out/io_oeb.

Parameters:
- NUM_TEAMS, 12, number of team designs; legal range 1..15.
- NUM_PINS, 34, number of muxed GPIO pins; legal range 1..128.
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the 256-byte register window.
- BLANK_CYCLES, 4, clocks of forced high-Z on changing pins during a commit; legal range 1..255.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane select.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- designs_gpio_out  in  NUM_TEAMS*NUM_PINS  team outputs; team t (1..NUM_TEAMS) occupies [(t-1)*NUM_PINS +: NUM_PINS].
- designs_gpio_oeb  in  NUM_TEAMS*NUM_PINS  team active-low output enables, same packing.
- gpio_out  out  NUM_PINS  muxed pin output.
- gpio_oeb  out  NUM_PINS  muxed active-low output enable.
- busy_o  out  1  commit sequence in progress.

Behaviour:
- One clock (wb_clk_i). Reset is synchronous and active-high (wb_rst_i).
- Reset values:
  - shadow and active selects = 0; FSM = IDLE; sticky drop flag = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, busy_o = 0.
  - gpio_out = all 0, gpio_oeb = all 1.
- Select encoding:
  - 4-bit field per pin; 0 = parked.
  - A value above NUM_TEAMS is stored as written but treated as parked.
  - Pin p lives in SEL word p/8, bits [4*(p%8) +: 4].
  - Fields for p >= NUM_PINS read 0 and ignore writes.
- Register map (offset from BASE_ADDR):
  - 0x00–0x3C: SEL0–SEL15 (shadow; R/W; byte lanes honour wbs_sel_i).
  - 0x40: CTRL. Write with bit0=1 starts a commit. Reads 0.
  - 0x44: STATUS. bit0 busy (RO); bit1 drop, sticky, write-1-to-clear.
  - Other offsets inside the window ack, read 0, ignore writes.
  - Addresses outside the window never ack.
- Bus timing:
  - Request = cyc & stb & in-window & !ack.
  - wbs_ack_o pulses 1 cycle, the clock after the request. wbs_dat_o is valid with ack and 0 otherwise.
  - Register updates take effect at the ack edge.
  - A master holding stb gets at most one ack per two cycles.
- FSM:
  - IDLE --CTRL.bit0 write--> BLANK. On entry, changed_mask[p] = (eff(shadow[p]) != eff(active[p])) and counter = BLANK_CYCLES-1.
  - BLANK: for masked pins, gpio_oeb=1 and gpio_out=0; unmasked pins are unaffected. Counter decrements each cycle. At 0 -> APPLY.
  - APPLY: active <= shadow for one cycle, mask cleared -> IDLE.
  - busy_o = 1 in BLANK and APPLY.
  - Commit with no differing pins still runs BLANK/APPLY but changes nothing visible.
- Writes while busy:
  - SEL writes are acked but dropped; drop flag set.
  - CTRL commit writes are acked and ignored; drop flag set.
  - Reads are always serviced.
- Pin datapath, registered (1-cycle latency from designs_* to gpio_*):
  - eff(active[p]) = 0: gpio_out=0, gpio_oeb=1.
  - Otherwise: the team's out/oeb bit for that pin.
- Simultaneous events: a drop-flag clear write in the same cycle a new drop occurs leaves the flag = 1.
- Reset mid-commit aborts the sequence: active selects return to 0 and all pins park.

Decomposition:
- Package gpio_mux_pkg holds:
  - register offsets (SEL_BASE, CTRL_OFF, STATUS_OFF);
  - SEL_FIELD_W=4, PINS_PER_WORD=8;
  - FSM state encoding (IDLE/BLANK/APPLY);
  - STATUS bit indices.
- One sub-module, gpio_mux_pin_sel: a combinational per-pin selector (active sel, team vectors -> out/oeb), instantiated NUM_PINS times via generate.
- Bus decode, shadow registers, FSM and output registers stay in the top.

Test Plan:
- Reset, NUM_TEAMS=3, NUM_PINS=34 -> gpio_oeb=34'h3_FFFF_FFFF, gpio_out=0, STATUS reads 0.
- Write SEL0=32'h0000_0021, commit, team1 oeb=0/out=1 on pin0 -> busy for BLANK_CYCLES+1 clocks; pin0 oeb=1 throughout BLANK; 1 clock after APPLY, pin0 out=1/oeb=0; pin1 follows team2.
- Write SEL0=32'h0000_0031 (pin1 2->3), commit -> only pin1 blanks for 4 cycles; pin0 toggles from team1 pass through unchanged.
- During BLANK, write SEL1=32'h1111_1111 -> acked, SEL1 reads back 0, STATUS=0x3; after the commit, write 0x2 to STATUS -> STATUS=0.
- SEL4 pin 32 = 4'hF with NUM_TEAMS=3, commit -> pin32 parked (oeb=1); SEL4 reads back 0x0000_000F; write byte lane 1 only -> lane 0 unchanged.
- Assert wb_rst_i during BLANK -> next clock busy_o=0, all pins parked, SEL regs read 0; access at BASE_ADDR+0x100 -> no ack within 8 cycles.
